rf_cmd_scheduler: RTL and testbench
===================================

Name: rf_cmd_scheduler

Overview:
- Sequences all register-file RAM traffic between the SDRAM load/store engine (rf_ldst) and the intra-RF move engine (rf_move).
- Accepts RF commands from the control unit into a small FIFO and dispatches them one at a time.
- Owns ram_sel so the single RF RAM port never switches owner mid-transfer.
- Replaces static ram_sel driving by the control unit; sits beside rf_wrapper.

Parameters:
- RF_ADDR_W, 10, RF line address width
- LINE_NUM_W, 11, transfer length width (lines)
- SDRAM_ADDR_W, 32, SDRAM byte address width
- QDEPTH, 4, command FIFO depth (power of 2, >=2)
- TIMEOUT_CYCLES, 65535, WAIT cycles before err_timeout is flagged

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_op  in  2  0=LOAD (SDRAM->RF), 1=STORE (RF->SDRAM), 2=MOVE, 3=illegal
- cmd_rf_addr  in  RF_ADDR_W  LOAD/STORE RF address; MOVE source
- cmd_dst_addr  in  RF_ADDR_W  MOVE destination
- cmd_sdram_addr  in  SDRAM_ADDR_W  LOAD/STORE SDRAM address
- cmd_len  in  LINE_NUM_W  line count
- ram_sel  out  1  1=ldst owns RF port, 0=move
- ldst_start  out  1  one-cycle start pulse
- ldst_is_store  out  1  direction
- ldst_rf_addr  out  RF_ADDR_W
- ldst_sdram_addr  out  SDRAM_ADDR_W
- ldst_len  out  LINE_NUM_W
- ldst_done  in  1  engine completion pulse
- move_start  out  1  one-cycle start pulse
- move_src  out  RF_ADDR_W
- move_dst  out  RF_ADDR_W
- move_len  out  LINE_NUM_W
- move_done  in  1  engine completion pulse
- cmd_done  out  1  one-cycle pulse per retired command
- busy  out  1  FSM not IDLE or FIFO non-empty
- q_count  out  $clog2(QDEPTH)+1  FIFO occupancy
- err_illegal  out  1  one-cycle pulse, op 3 rejected
- err_timeout  out  1  sticky until rst

Behaviour:
- Reset: FIFO emptied, FSM=IDLE. All outputs 0 except cmd_ready=1. Reset mid-transfer aborts with no cmd_done.
- Accept: on cmd_valid && cmd_ready. cmd_ready = (q_count != QDEPTH), from registered count only; a same-cycle pop does not free a slot for a push.
- op 3: cmd_ready stays high, command not enqueued, err_illegal pulses the next cycle.
- FIFO: order preserved; push and pop in the same cycle leave q_count unchanged.
- FSM states: IDLE, SETUP, START, WAIT, RETIRE.
- IDLE: if FIFO non-empty, pop head into command register, go to SETUP.
- SETUP: drive ram_sel (1 for LOAD/STORE, 0 for MOVE) and the engine argument outputs; hold one cycle for mux settle. If len==0, go to RETIRE with no start pulse; else go to START.
- START: pulse ldst_start or move_start for exactly one cycle; go to WAIT.
- WAIT: ram_sel and arguments held stable.
  - Leave on the selected engine's done pulse.
  - The non-selected engine's done is ignored. Done outside WAIT is ignored.
  - A cycle counter counts from WAIT entry; at TIMEOUT_CYCLES, err_timeout sets (sticky) and the FSM keeps waiting.
- RETIRE: pulse cmd_done one cycle; go to IDLE.
- ram_sel keeps its last value in IDLE and changes only on the SETUP entry edge.
- Latency, empty FIFO: command accepted at edge N, pop at N+1, start pulse high in cycle N+3. Done pulse at edge D gives cmd_done high in cycle D+1; the next queued command's start is high in cycle D+4.
- Argument outputs are registered and change only on SETUP entry.

Test Plan:
- Reset, then LOAD rf=0x010 sdram=0x1000 len=8 -> ram_sel=1, ldst_is_store=0, ldst_start high 3 cycles after accept; ldst_done 20 cycles later -> cmd_done 1 cycle after done, busy=0 one cycle after.
- Queue STORE, MOVE(src=5, dst=9, len=3), LOAD back-to-back -> dispatched in order. ram_sel 1->0->1, switching only at SETUP. Exactly one start per command; move_done asserted during the STORE is ignored.
- Push 5 commands with engine stalled -> cmd_ready low after 4 accepted, q_count=4; 5th held until first pop, then accepted.
- cmd_op=3 -> err_illegal pulse, q_count unchanged, no start; len=0 MOVE -> cmd_done, no move_start.
- TIMEOUT_CYCLES=16, withhold done -> err_timeout set at WAIT cycle 16 and stays set. Late done still retires the command.
- rst during WAIT -> all outputs 0 next cycle, q_count=0, no cmd_done. A new command then runs normally.

Source files
------------

// File: rtl/rf_cmd_scheduler.sv
// Register-file command scheduler: queues LOAD/STORE/MOVE commands and dispatches them
// one at a time to rf_ldst or rf_move, owning ram_sel so the RF port never changes owner mid-transfer.
module rf_cmd_scheduler #(
   parameter int unsigned RF_ADDR_W      = 10,
   parameter int unsigned LINE_NUM_W     = 11,
   parameter int unsigned SDRAM_ADDR_W   = 32,
   parameter int unsigned QDEPTH         = 4,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [1:0]                cmd_op,
   input  logic [RF_ADDR_W-1:0]      cmd_rf_addr,
   input  logic [RF_ADDR_W-1:0]      cmd_dst_addr,
   input  logic [SDRAM_ADDR_W-1:0]   cmd_sdram_addr,
   input  logic [LINE_NUM_W-1:0]     cmd_len,
   output logic                      ram_sel,
   output logic                      ldst_start,
   output logic                      ldst_is_store,
   output logic [RF_ADDR_W-1:0]      ldst_rf_addr,
   output logic [SDRAM_ADDR_W-1:0]   ldst_sdram_addr,
   output logic [LINE_NUM_W-1:0]     ldst_len,
   input  logic                      ldst_done,
   output logic                      move_start,
   output logic [RF_ADDR_W-1:0]      move_src,
   output logic [RF_ADDR_W-1:0]      move_dst,
   output logic [LINE_NUM_W-1:0]     move_len,
   input  logic                      move_done,
   output logic                      cmd_done,
   output logic                      busy,
   output logic [$clog2(QDEPTH):0]   q_count,
   output logic                      err_illegal,
   output logic                      err_timeout
);

   localparam int unsigned PTR_W = $clog2(QDEPTH);
   localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [1:0] OP_STORE = 2'd1;
   localparam logic [1:0] OP_MOVE  = 2'd2;
   localparam logic [1:0] OP_ILL   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_RETIRE = 3'd4
   } state_t;

   state_t state, state_next;

   logic [1:0]              fifo_op    [QDEPTH];
   logic [RF_ADDR_W-1:0]    fifo_rf    [QDEPTH];
   logic [RF_ADDR_W-1:0]    fifo_dst   [QDEPTH];
   logic [SDRAM_ADDR_W-1:0] fifo_sdram [QDEPTH];
   logic [LINE_NUM_W-1:0]   fifo_len   [QDEPTH];

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count_next;
   logic [TMR_W-1:0] tmr;

   logic push, pop, illegal, done_sel;
   logic cur_is_ldst, cur_len_zero;
   logic ldst_start_d, move_start_d, cmd_done_d, busy_d, cmd_ready_d;

   logic [1:0]              head_op;
   logic [RF_ADDR_W-1:0]    head_rf, head_dst;
   logic [SDRAM_ADDR_W-1:0] head_sdram;
   logic [LINE_NUM_W-1:0]   head_len;

   assign push     = cmd_valid && cmd_ready && (cmd_op != OP_ILL);
   assign illegal  = cmd_valid && cmd_ready && (cmd_op == OP_ILL);
   assign pop      = (state == S_IDLE) && (q_count != '0);
   assign done_sel = cur_is_ldst ? ldst_done : move_done;

   assign head_op    = fifo_op[rd_ptr];
   assign head_rf    = fifo_rf[rd_ptr];
   assign head_dst   = fifo_dst[rd_ptr];
   assign head_sdram = fifo_sdram[rd_ptr];
   assign head_len   = fifo_len[rd_ptr];

   // Occupancy after this edge; a same-cycle push and pop cancel out.
   always_comb begin
      count_next = q_count;
      case ({push, pop})
         2'b10:   count_next = q_count + CNT_W'(1);
         2'b01:   count_next = q_count - CNT_W'(1);
         default: count_next = q_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         q_count <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr]    <= cmd_op;
         fifo_rf[wr_ptr]    <= cmd_rf_addr;
         fifo_dst[wr_ptr]   <= cmd_dst_addr;
         fifo_sdram[wr_ptr] <= cmd_sdram_addr;
         fifo_len[wr_ptr]   <= cmd_len;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (q_count != '0) state_next = S_SETUP;
         S_SETUP:  state_next = cur_len_zero ? S_RETIRE : S_START;
         S_START:  state_next = S_WAIT;
         S_WAIT:   if (done_sel) state_next = S_RETIRE;
         S_RETIRE: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Next values of the registered pulse/status outputs, decoded from the next state.
   always_comb begin
      ldst_start_d = 1'b0;
      move_start_d = 1'b0;
      cmd_done_d   = 1'b0;
      busy_d       = (state_next != S_IDLE) || (count_next != '0);
      cmd_ready_d  = (count_next != CNT_W'(QDEPTH));
      if (state_next == S_START) begin
         ldst_start_d = cur_is_ldst;
         move_start_d = !cur_is_ldst;
      end
      if (state_next == S_RETIRE) cmd_done_d = 1'b1;
   end

   // WAIT cycle counter, saturating so the timeout flag is raised once.
   always_ff @(posedge clk) begin
      if (rst)                                 tmr <= '0;
      else if (state != S_WAIT)                tmr <= '0;
      else if (tmr != TMR_W'(TIMEOUT_CYCLES))  tmr <= tmr + TMR_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_ready       <= 1'b1;
         ldst_start      <= 1'b0;
         move_start      <= 1'b0;
         cmd_done        <= 1'b0;
         busy            <= 1'b0;
         err_illegal     <= 1'b0;
         err_timeout     <= 1'b0;
         ram_sel         <= 1'b0;
         cur_is_ldst     <= 1'b0;
         cur_len_zero    <= 1'b0;
         ldst_is_store   <= 1'b0;
         ldst_rf_addr    <= '0;
         ldst_sdram_addr <= '0;
         ldst_len        <= '0;
         move_src        <= '0;
         move_dst        <= '0;
         move_len        <= '0;
      end else begin
         cmd_ready   <= cmd_ready_d;
         ldst_start  <= ldst_start_d;
         move_start  <= move_start_d;
         cmd_done    <= cmd_done_d;
         busy        <= busy_d;
         err_illegal <= illegal;
         if ((state == S_WAIT) && (tmr == TMR_W'(TIMEOUT_CYCLES - 1))) err_timeout <= 1'b1;
         // Port owner and engine arguments only move on the SETUP entry edge.
         if (pop) begin
            ram_sel      <= (head_op != OP_MOVE);
            cur_is_ldst  <= (head_op != OP_MOVE);
            cur_len_zero <= (head_len == '0);
            if (head_op != OP_MOVE) begin
               ldst_is_store   <= (head_op == OP_STORE);
               ldst_rf_addr    <= head_rf;
               ldst_sdram_addr <= head_sdram;
               ldst_len        <= head_len;
            end else begin
               move_src <= head_rf;
               move_dst <= head_dst;
               move_len <= head_len;
            end
         end
      end
   end

endmodule

// File: tb/tb_rf_cmd_scheduler.sv
// Directed bench for rf_cmd_scheduler: expected dispatches are queued when commands are
// driven and checked against each start pulse.
module tb_rf_cmd_scheduler;

   localparam int unsigned RA = 10;
   localparam int unsigned LW = 11;
   localparam int unsigned SW = 32;
   localparam int unsigned QD = 4;
   localparam int unsigned TO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [1:0]    cmd_op = '0;
   logic [RA-1:0] cmd_rf_addr = '0;
   logic [RA-1:0] cmd_dst_addr = '0;
   logic [SW-1:0] cmd_sdram_addr = '0;
   logic [LW-1:0] cmd_len = '0;
   logic          ram_sel;
   logic          ldst_start, ldst_is_store;
   logic [RA-1:0] ldst_rf_addr;
   logic [SW-1:0] ldst_sdram_addr;
   logic [LW-1:0] ldst_len;
   logic          ldst_done = 1'b0;
   logic          move_start;
   logic [RA-1:0] move_src, move_dst;
   logic [LW-1:0] move_len;
   logic          move_done = 1'b0;
   logic          cmd_done, busy;
   logic [$clog2(QD):0] q_count;
   logic          err_illegal, err_timeout;

   always #5 clk = ~clk;

   rf_cmd_scheduler #(
      .RF_ADDR_W(RA), .LINE_NUM_W(LW), .SDRAM_ADDR_W(SW), .QDEPTH(QD), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rf_addr(cmd_rf_addr), .cmd_dst_addr(cmd_dst_addr),
      .cmd_sdram_addr(cmd_sdram_addr), .cmd_len(cmd_len),
      .ram_sel(ram_sel),
      .ldst_start(ldst_start), .ldst_is_store(ldst_is_store), .ldst_rf_addr(ldst_rf_addr),
      .ldst_sdram_addr(ldst_sdram_addr), .ldst_len(ldst_len), .ldst_done(ldst_done),
      .move_start(move_start), .move_src(move_src), .move_dst(move_dst),
      .move_len(move_len), .move_done(move_done),
      .cmd_done(cmd_done), .busy(busy), .q_count(q_count),
      .err_illegal(err_illegal), .err_timeout(err_timeout)
   );

   typedef struct {
      logic          is_move;
      logic          is_store;
      logic [RA-1:0] a;
      logic [RA-1:0] b;
      logic [SW-1:0] sd;
      logic [LW-1:0] len;
   } exp_t;

   exp_t sbq[$];
   int total = 0;
   int bad   = 0;
   int n_ldst = 0, n_move = 0, n_done = 0;

   always @(posedge clk) begin
      if (ldst_start) n_ldst <= n_ldst + 1;
      if (move_start) n_move <= n_move + 1;
      if (cmd_done)   n_done <= n_done + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
   endtask

   // Offer one command, hold until accepted, and record the dispatch it should cause.
   task automatic send(input logic [1:0] op, input logic [RA-1:0] a, input logic [RA-1:0] b,
                       input logic [SW-1:0] sd, input logic [LW-1:0] len);
      int   n;
      exp_t e;
      n = 0;
      cmd_valid = 1'b1; cmd_op = op; cmd_rf_addr = a; cmd_dst_addr = b;
      cmd_sdram_addr = sd; cmd_len = len;
      while (!cmd_ready && n < 50) begin tick; n++; end
      chk("send_ready", 64'(cmd_ready), 64'(1));
      tick;
      cmd_valid = 1'b0;
      if (op != 2'd3 && len != '0) begin
         e.is_move = (op == 2'd2); e.is_store = (op == 2'd1);
         e.a = a; e.b = b; e.sd = sd; e.len = len;
         sbq.push_back(e);
      end
   endtask

   task automatic check_start(input int budget, output int n);
      exp_t e;
      n = 0;
      while (!(ldst_start || move_start) && n < budget) begin tick; n++; end
      chk("start_seen", 64'(ldst_start | move_start), 64'(1));
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'(1));
      if (sbq.size() != 0 && (ldst_start || move_start)) begin
         e = sbq.pop_front();
         chk("ram_sel", 64'(ram_sel), 64'(!e.is_move));
         chk("move_start", 64'(move_start), 64'(e.is_move));
         chk("ldst_start", 64'(ldst_start), 64'(!e.is_move));
         if (e.is_move) begin
            chk("move_src", 64'(move_src), 64'(e.a));
            chk("move_dst", 64'(move_dst), 64'(e.b));
            chk("move_len", 64'(move_len), 64'(e.len));
         end else begin
            chk("ldst_is_store", 64'(ldst_is_store), 64'(e.is_store));
            chk("ldst_rf_addr", 64'(ldst_rf_addr), 64'(e.a));
            chk("ldst_sdram_addr", 64'(ldst_sdram_addr), 64'(e.sd));
            chk("ldst_len", 64'(ldst_len), 64'(e.len));
         end
      end
   endtask

   // From the START sample: enter WAIT, pulse the engine's done, expect cmd_done.
   task automatic finish_cmd(input logic is_move);
      tick;
      if (is_move) move_done = 1'b1;
      else         ldst_done = 1'b1;
      tick;
      ldst_done = 1'b0;
      move_done = 1'b0;
      chk("cmd_done", 64'(cmd_done), 64'(1));
   endtask

   initial begin
      int n;
      int s_l, s_m, s_d;

      // Reset state
      do_reset;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("rst_ram_sel", 64'(ram_sel), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_q_count", 64'(q_count), 64'(0));
      chk("rst_starts", 64'({ldst_start, move_start}), 64'(0));
      chk("rst_errs", 64'({err_illegal, err_timeout}), 64'(0));
      chk("rst_cmd_done", 64'(cmd_done), 64'(0));

      // Single LOAD, done 20 cycles into WAIT
      send(2'd0, 10'h010, 10'h000, 32'h1000, 11'd8);
      check_start(6, n);
      chk("load_latency", 64'(n), 64'(2));
      tick;
      chk("start_one_cycle", 64'(ldst_start), 64'(0));
      repeat (19) tick;
      ldst_done = 1'b1;
      tick;
      ldst_done = 1'b0;
      chk("load_cmd_done", 64'(cmd_done), 64'(1));
      chk("load_ram_sel_held", 64'(ram_sel), 64'(1));
      tick;
      chk("load_cmd_done_pulse", 64'(cmd_done), 64'(0));
      chk("load_busy_clear", 64'(busy), 64'(0));
      chk("load_long_wait_timeout", 64'(err_timeout), 64'(1));

      // STORE, MOVE, LOAD back to back
      do_reset;
      chk("timeout_cleared", 64'(err_timeout), 64'(0));
      s_l = n_ldst; s_m = n_move;
      send(2'd1, 10'h020, 10'h000, 32'h2000, 11'd4);
      send(2'd2, 10'h005, 10'h009, 32'h0, 11'd3);
      send(2'd0, 10'h030, 10'h000, 32'h3000, 11'd2);
      check_start(6, n);
      chk("q_count_two", 64'(q_count), 64'(2));
      tick;
      move_done = 1'b1;
      tick;
      move_done = 1'b0;
      chk("foreign_done_ignored", 64'(cmd_done), 64'(0));
      chk("ram_sel_store_wait", 64'(ram_sel), 64'(1));
      repeat (3) tick;
      chk("still_waiting", 64'(cmd_done), 64'(0));
      ldst_done = 1'b1;
      tick;
      ldst_done = 1'b0;
      chk("store_cmd_done", 64'(cmd_done), 64'(1));
      chk("ram_sel_held_retire", 64'(ram_sel), 64'(1));
      check_start(8, n);
      chk("next_start_latency", 64'(n), 64'(3));
      tick;
      ldst_done = 1'b1;
      tick;
      ldst_done = 1'b0;
      chk("ldst_done_ignored_move", 64'(cmd_done), 64'(0));
      move_done = 1'b1;
      tick;
      move_done = 1'b0;
      chk("move_cmd_done", 64'(cmd_done), 64'(1));
      check_start(8, n);
      finish_cmd(1'b0);
      tick;
      chk("seq_busy_clear", 64'(busy), 64'(0));
      chk("seq_ldst_starts", 64'(n_ldst - s_l), 64'(2));
      chk("seq_move_starts", 64'(n_move - s_m), 64'(1));

      // Fill the FIFO behind a stalled LOAD
      do_reset;
      send(2'd0, 10'h040, 10'h000, 32'h4000, 11'd5);
      check_start(6, n);
      send(2'd2, 10'h001, 10'h002, 32'h0, 11'd6);
      send(2'd1, 10'h050, 10'h000, 32'h5000, 11'd7);
      send(2'd2, 10'h003, 10'h004, 32'h0, 11'd1);
      send(2'd0, 10'h060, 10'h000, 32'h6000, 11'd9);
      chk("full_q_count", 64'(q_count), 64'(4));
      chk("full_not_ready", 64'(cmd_ready), 64'(0));
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_rf_addr = 10'h070; cmd_dst_addr = '0;
      cmd_sdram_addr = 32'h7000; cmd_len = 11'd2;
      sbq.push_back('{is_move: 1'b0, is_store: 1'b1, a: 10'h070, b: 10'h000,
                      sd: 32'h7000, len: 11'd2});
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("fifth_held", 64'(q_count), 64'(4));
      end
      ldst_done = 1'b1;
      tick;
      ldst_done = 1'b0;
      chk("stalled_load_done", 64'(cmd_done), 64'(1));
      n = 0;
      while (!cmd_ready && n < 10) begin tick; n++; end
      chk("ready_after_pop", 64'(cmd_ready), 64'(1));
      chk("ready_after_pop_latency", 64'(n), 64'(2));
      tick;
      cmd_valid = 1'b0;
      chk("fifth_accepted", 64'(q_count), 64'(4));
      check_start(6, n); finish_cmd(1'b1);
      check_start(6, n); finish_cmd(1'b0);
      check_start(6, n); finish_cmd(1'b1);
      check_start(6, n); finish_cmd(1'b0);
      check_start(6, n); finish_cmd(1'b0);
      tick;
      chk("drain_busy", 64'(busy), 64'(0));
      chk("drain_q_count", 64'(q_count), 64'(0));

      // Illegal op and zero-length MOVE
      do_reset;
      s_l = n_ldst; s_m = n_move;
      send(2'd3, 10'h011, 10'h022, 32'h9999, 11'd5);
      chk("illegal_pulse", 64'(err_illegal), 64'(1));
      chk("illegal_q_count", 64'(q_count), 64'(0));
      chk("illegal_ready", 64'(cmd_ready), 64'(1));
      tick;
      chk("illegal_one_cycle", 64'(err_illegal), 64'(0));
      repeat (4) tick;
      chk("illegal_not_busy", 64'(busy), 64'(0));
      send(2'd2, 10'h007, 10'h008, 32'h0, 11'd0);
      n = 0;
      while (!cmd_done && n < 8) begin tick; n++; end
      chk("len0_cmd_done", 64'(cmd_done), 64'(1));
      chk("len0_latency", 64'(n), 64'(2));
      chk("len0_ram_sel", 64'(ram_sel), 64'(0));
      tick;
      tick;
      chk("len0_no_ldst_start", 64'(n_ldst - s_l), 64'(0));
      chk("len0_no_move_start", 64'(n_move - s_m), 64'(0));

      // Timeout with a late done
      do_reset;
      send(2'd0, 10'h011, 10'h000, 32'h1100, 11'd3);
      check_start(6, n);
      repeat (16) tick;
      chk("timeout_not_yet", 64'(err_timeout), 64'(0));
      tick;
      chk("timeout_set", 64'(err_timeout), 64'(1));
      repeat (5) tick;
      chk("timeout_sticky", 64'(err_timeout), 64'(1));
      finish_cmd(1'b0);
      tick;
      chk("timeout_sticky_after_retire", 64'(err_timeout), 64'(1));
      chk("timeout_busy_clear", 64'(busy), 64'(0));

      // Reset during WAIT, then normal operation
      do_reset;
      send(2'd2, 10'h015, 10'h025, 32'h0, 11'd4);
      check_start(6, n);
      tick;
      tick;
      s_d = n_done;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("abort_ram_sel", 64'(ram_sel), 64'(0));
      chk("abort_move_args", 64'({move_src, move_dst, move_len}), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_q_count", 64'(q_count), 64'(0));
      chk("abort_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("abort_cmd_done", 64'(cmd_done), 64'(0));
      repeat (4) tick;
      chk("abort_no_done", 64'(n_done - s_d), 64'(0));
      send(2'd0, 10'h033, 10'h000, 32'h3300, 11'd6);
      check_start(6, n);
      chk("post_abort_latency", 64'(n), 64'(2));
      finish_cmd(1'b0);
      tick;
      chk("post_abort_busy", 64'(busy), 64'(0));
      chk("sb_empty", 64'(sbq.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
